// File: rtl/mc_fetch_mem.sv
// Fetch / memory-access stage of the multicycle MIPS datapath.
// Owns PC, IR and MDR, runs a three-state memory handshake FSM and
// stalls the controller until each access completes or times out.
module mc_fetch_mem #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcwrite,
  input  logic        pcwritecond,
  input  logic        iord,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        irwrite,
  input  logic [1:0]  pcsource,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] b_reg,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic [5:0]  op,
  output logic        stall,
  output logic        bus_err
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, ir_q, mdr_q, mem_addr_q, mem_wdata_q;
  logic          mem_rd_q, mem_wr_q, ir_pend_q, bus_err_q;
  logic [CW-1:0] cnt_q;
  logic          req, timeout, pc_en;

  assign req     = memread | memwrite;
  // Last permitted ACCESS cycle without ready; ready on that cycle still wins.
  assign timeout = (cnt_q == CW'(WAIT_MAX - 1)) && !mem_ready;
  assign stall   = ((state_q == IDLE) && req) || (state_q == ACCESS);
  assign pc_en   = !stall && (pcwrite || (pcwritecond && zero));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (mem_ready || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus request, wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      ir_pend_q   <= 1'b0;
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          mem_addr_q  <= iord ? alu_out : pc_q;
          mem_wdata_q <= b_reg;
          mem_rd_q    <= memread;
          // A simultaneous read and write performs only the read.
          mem_wr_q    <= memwrite & ~memread;
          ir_pend_q   <= irwrite & memread;
          cnt_q       <= '0;
          if (memread && memwrite) bus_err_q <= 1'b1;
        end
        ACCESS: begin
          if (mem_ready || timeout) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (!mem_ready) bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // IR / MDR capture on a completed read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q  <= '0;
      mdr_q <= '0;
    end else if ((state_q == ACCESS) && mem_ready) begin
      if (mem_rd_q)  mdr_q <= mem_rdata;
      if (ir_pend_q) ir_q  <= mem_rdata;
    end
  end

  // Next-PC select
  always_comb begin
    pc_d = pc_q;
    case (pcsource)
      2'b00: pc_d = alu_result;
      2'b01: pc_d = alu_out;
      2'b10: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default: pc_d = pc_q;
    endcase
  end

  // PC register, never written while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_q <= RESET_PC;
    else if (pc_en) pc_q <= pc_d;
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign op        = ir_q[31:26];
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mc_fetch_mem.sv
// Scoreboard bench for mc_fetch_mem: stimulus pushes the expected bus
// transaction, a negedge monitor pops and compares when each access ends.
module tb_mc_fetch_mem;
  localparam int WM = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        pcwrite = 0, pcwritecond = 0, iord = 0, memread = 0, memwrite = 0, irwrite = 0;
  logic [1:0]  pcsource = 2'b00;
  logic        zero = 0;
  logic [31:0] alu_result = 0, alu_out = 0, b_reg = 0, mem_rdata = 0;
  logic        mem_ready = 0;
  logic [31:0] mem_addr, mem_wdata, pc, ir, mdr;
  logic        mem_rd, mem_wr, stall, bus_err;
  logic [5:0]  op;

  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        rd, wr;
    logic [31:0] ir, mdr;
    logic        berr;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  mc_fetch_mem #(.RESET_PC(32'h0), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .pcsource(pcsource), .zero(zero), .alu_result(alu_result), .alu_out(alu_out),
    .b_reg(b_reg), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .ir(ir), .mdr(mdr), .op(op), .stall(stall), .bus_err(bus_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One memory access: strobes held from IDLE through the DONE edge.
  task automatic access(input logic rd, input logic wr, input logic iord_v,
                        input logic irw, input logic pcw, input logic [1:0] psrc,
                        input int ready_at, input logic [31:0] rdata, input exp_t e);
    logic [31:0] pc0;
    int k;
    sb.push_back(e);
    pc0 = pc;
    memread = rd; memwrite = wr; iord = iord_v; irwrite = irw;
    pcwrite = pcw; pcsource = psrc;
    @(posedge clk); #1;
    k = 1;
    while ((mem_rd || mem_wr) && k <= 20) begin
      chk("pc_hold_stall", pc, pc0);
      mem_ready = (k == ready_at);
      mem_rdata = rdata;
      @(posedge clk); #1;
      k++;
    end
    mem_ready = 1'b0;
    chk("access_bounded", {31'b0, (mem_rd | mem_wr)}, 32'd0);
    @(posedge clk); #1;
    memread = 0; memwrite = 0; iord = 0; irwrite = 0; pcwrite = 0; pcsource = 2'b00;
  endtask

  // One PC-update cycle with no memory request.
  task automatic pcop(input logic pcw, input logic pcc, input logic z, input logic [1:0] psrc);
    pcwrite = pcw; pcwritecond = pcc; zero = z; pcsource = psrc;
    @(posedge clk); #1;
    pcwrite = 0; pcwritecond = 0; zero = 0; pcsource = 2'b00;
  endtask

  // Monitor: records the request while active, compares at the DONE cycle.
  initial begin
    logic active;
    int st;
    exp_t a, e;
    active = 0; st = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; st = 0;
      end else begin
        if (stall) st++;
        if (mem_rd || mem_wr) begin
          if (!active) begin
            a.addr = mem_addr; a.wdata = mem_wdata; a.rd = mem_rd; a.wr = mem_wr;
            active = 1;
          end
        end else if (active) begin
          active = 0;
          if (sb.size() == 0) begin
            chk("unexpected_txn", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("mem_addr", a.addr, e.addr);
            chk("mem_wdata", a.wdata, e.wdata);
            chk("mem_rd", {31'b0, a.rd}, {31'b0, e.rd});
            chk("mem_wr", {31'b0, a.wr}, {31'b0, e.wr});
            chk("ir", ir, e.ir);
            chk("mdr", mdr, e.mdr);
            chk("bus_err", {31'b0, bus_err}, {31'b0, e.berr});
            chk("stall_cycles", st, e.stalls);
          end
          st = 0;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_op", {26'b0, op}, 32'h0);
    chk("rst_rdwr", {30'b0, mem_rd, mem_wr}, 32'h0);
    chk("rst_berr", {31'b0, bus_err}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait instruction fetch with PC+4
    alu_result = 32'h4;
    access(1, 0, 0, 1, 1, 2'b00, 1, 32'h8C22_0004,
           '{32'h0, 32'h0, 1'b1, 1'b0, 32'h8C22_0004, 32'h8C22_0004, 1'b0, 2});
    chk("fetch_pc", pc, 32'h4);
    chk("fetch_op", {26'b0, op}, 32'h23);

    // wait-stated load via ALUOut
    alu_out = 32'h100;
    access(1, 0, 1, 0, 0, 2'b00, 3, 32'h1234_5678,
           '{32'h100, 32'h0, 1'b1, 1'b0, 32'h8C22_0004, 32'h1234_5678, 1'b0, 4});
    chk("load_pc", pc, 32'h4);

    // store
    b_reg = 32'hDEAD_BEEF; alu_out = 32'h200;
    access(0, 1, 1, 0, 0, 2'b00, 1, 32'hFFFF_FFFF,
           '{32'h200, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8C22_0004, 32'h1234_5678, 1'b0, 2});

    // branch not taken / taken, then set up an upper PC nibble
    alu_out = 32'h80;
    pcop(0, 1, 0, 2'b01); chk("br_nt_pc", pc, 32'h4);
    pcop(0, 1, 1, 2'b01); chk("br_t_pc", pc, 32'h80);
    alu_result = 32'hA000_0000;
    pcop(1, 0, 0, 2'b00); chk("pc_alu", pc, 32'hA000_0000);

    // fetch a jump, then take it and hold
    b_reg = 32'h0;
    access(1, 0, 0, 1, 0, 2'b00, 2, 32'h0800_0040,
           '{32'hA000_0000, 32'h0, 1'b1, 1'b0, 32'h0800_0040, 32'h0800_0040, 1'b0, 3});
    chk("j_op", {26'b0, op}, 32'h2);
    pcop(1, 0, 0, 2'b10); chk("jump_pc", pc, 32'hA000_0100);
    pcop(1, 0, 0, 2'b11); chk("hold_pc", pc, 32'hA000_0100);

    // timeout, then a normal access keeps bus_err sticky
    access(1, 0, 0, 1, 0, 2'b00, 0, 32'h1111_1111,
           '{32'hA000_0100, 32'h0, 1'b1, 1'b0, 32'h0800_0040, 32'h0800_0040, 1'b1, WM + 1});
    alu_out = 32'h300;
    access(1, 0, 1, 0, 0, 2'b00, 1, 32'h2222_2222,
           '{32'h300, 32'h0, 1'b1, 1'b0, 32'h0800_0040, 32'h2222_2222, 1'b1, 2});

    // reset in the middle of an access
    memread = 1; irwrite = 1; mem_rdata = 32'h3333_3333;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_rd", {31'b0, mem_rd}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_rdwr", {30'b0, mem_rd, mem_wr}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_ir", ir, 32'h0);
    chk("mid_rst_mdr", mdr, 32'h0);
    chk("mid_rst_op", {26'b0, op}, 32'h0);
    chk("mid_rst_berr", {31'b0, bus_err}, 32'h0);
    memread = 0; irwrite = 0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // read and write together: read wins, bus_err set
    access(1, 1, 0, 0, 0, 2'b00, 1, 32'h55AA_55AA,
           '{32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h55AA_55AA, 1'b1, 2});

    repeat (3) @(posedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_fetch_mem.md
# mc_fetch_mem

Fetch and memory-access stage of the multicycle MIPS datapath, directly upstream of the control state machine. Holds PC, instruction register (IR) and memory data register (MDR), and drives the `op[5:0]` field the controller decodes. Executes the controller's `iord`/`memread`/`memwrite`/`irwrite`/`pcwrite*`/`pcsource*` strobes against a ready-handshaked memory, and raises `stall` so the controller holds its state until the access completes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value on reset.
- `WAIT_MAX`, default 8: maximum ACCESS cycles before a bus timeout (≥1).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `irwrite`  in  1 each  controller strobes.
- `pcsource`  in  2  {pcsource1, pcsource0}.
- `zero`  in  1  ALU zero flag.
- `alu_result`  in  32  combinational ALU output.
- `alu_out`  in  32  ALUOut register.
- `b_reg`  in  32  store data.
- `mem_addr`  out  32  registered memory address.
- `mem_wdata`  out  32  registered store data.
- `mem_rd`, `mem_wr`  out  1 each  registered memory request.
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  access complete.
- `pc`, `ir`, `mdr`  out  32 each  architectural registers.
- `op`  out  6  `ir[31:26]`, feeds the controller.
- `stall`  out  1  controller state-hold enable.
- `bus_err`  out  1  sticky error flag.

## Operation
- Memory FSM states: IDLE, ACCESS, DONE.
- IDLE: `req = memread | memwrite`. On `req`:
  - latch `mem_addr = iord ? alu_out : pc` and `mem_wdata = b_reg`;
  - set `mem_rd = memread`, `mem_wr = memwrite & ~memread`;
  - latch `irwrite & memread` as `ir_pend`;
  - go to ACCESS.
- Read and write together: the read is performed and `bus_err` is set.
- ACCESS: request outputs held stable; the cycle counter increments.
  - `mem_ready` high: `MDR <= mem_rdata` (reads only); if `ir_pend`, `IR <= mem_rdata`; clear `mem_rd`/`mem_wr`; go to DONE.
  - Counter reaches `WAIT_MAX` without ready: clear the request, set `bus_err`, go to DONE. MDR and IR are left unchanged.
- DONE: go to IDLE unconditionally. The controller advances on this edge.
- `stall = (IDLE & req) | ACCESS`. It is combinational from the FSM state and the strobes.
- PC update: `pc_en = ~stall & (pcwrite | (pcwritecond & zero))`. Next PC by `pcsource`:
  - 00: `alu_result`
  - 01: `alu_out`
  - 10: `{pc[31:28], ir[25:0], 2'b00}`
  - 11: hold
- `op = ir[31:26]`, combinational.
- Reset values: `pc = RESET_PC`; `ir`, `mdr`, `mem_addr`, `mem_wdata` = 0; `mem_rd`, `mem_wr`, `bus_err`, counter = 0; FSM in IDLE; `op = 0`; `stall` follows the strobes.
- `bus_err` clears only on reset.

## Timing
- Minimum access is 3 cycles: IDLE detect, ACCESS with `mem_ready` in the first cycle, DONE. Each wait cycle adds one cycle.
- `mem_ready` is sampled only in ACCESS. A ready pulse in IDLE or DONE is ignored.
- IR and MDR become visible the cycle after the ready edge, i.e. in DONE. The controller sees the new `op` when it leaves the fetch state.
- Controller strobes are sampled only on the IDLE→ACCESS edge. Changes during ACCESS have no effect.
- PC is never written while `stall = 1`. A fetch state carrying `pcwrite` commits PC+4 in DONE, exactly once.
- Reset asserted mid-ACCESS: request outputs drop immediately (asynchronous), FSM returns to IDLE, and no partial IR/MDR write occurs.
- Back-to-back accesses: a new `req` in IDLE right after DONE starts a new access with no bubble.

## Test plan
- Reset: assert `rst_n = 0` mid-run -> `pc = RESET_PC`, `ir = 0`, `op = 0`, `mem_rd = mem_wr = 0`, `bus_err = 0`, same cycle.
- Zero-wait fetch: `memread = irwrite = pcwrite = 1`, `iord = 0`, `pcsource = 00`, `alu_result = pc+4`, memory returns 32'h8C22_0004 with ready in the first ACCESS cycle -> `stall` high 2 cycles, `ir = 32'h8C22_0004`, `op = 6'b100011`, PC += 4 once.
- Wait-stated load: `iord = 1`, `alu_out = 32'h100`, ready after 3 ACCESS cycles -> `mem_addr = 32'h100`, `stall` high 4 cycles, `mdr = rdata`, IR unchanged.
- Store: `memwrite = 1`, `b_reg = 32'hDEAD_BEEF` -> `mem_wr = 1`, `mem_wdata = 32'hDEAD_BEEF`, `mem_rd = 0`, MDR unchanged.
- Branch and jump:
  - `pcwritecond = 1`, `zero = 0` -> PC holds;
  - `zero = 1`, `pcsource = 01` -> `pc = alu_out`;
  - `pcsource = 10`, `ir[25:0] = 26'h00_0040` -> `pc = {pc[31:28], 28'h000_0100}`.
- Timeout: `mem_ready` held low, `WAIT_MAX = 8` -> DONE after 8 ACCESS cycles, `bus_err = 1` sticky, IR/MDR unchanged; `memread & memwrite` together also sets `bus_err`.
